// File: rtl/rx_fsm_4bit.sv
`default_nettype none
// ============================================================================
// Module   : rx_fsm_4bit
// Purpose  : Serial receiver for 4-bit frames (start, A..D, [parity], stop).
//            Optional even parity is enabled by defining macro RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rx_fsm_4bit #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [3:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy,
  output logic       parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] c_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] c_BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            rx_meta_q, rx_s_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      shift_q, shift_d;
  logic [3:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            perr_q, perr_d;
`ifdef RX_PARITY_EN
  logic            par_q, par_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
`ifdef RX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
`ifdef RX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
`ifdef RX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = S_START;
          idx_d   = '0;
        end
      end
      S_START: begin
        // Half-bit check rejects short glitches and aligns later samples to mid-bit
        if (cnt_q == c_HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == c_BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          idx_d          = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
`ifdef RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == c_BIT_LAST) begin
          cnt_d   = '0;
          par_d   = rx_s_q;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == c_BIT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rx_s_q) begin
`ifdef RX_PARITY_EN
            if (par_q != ^shift_q) begin
              perr_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              data_d  = shift_q;
            end
`else
            valid_d = 1'b1;
            data_d  = shift_q;
`endif
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rx_fsm_4bit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_rx_fsm_4bit
// Purpose  : Directed scoreboard bench for rx_fsm_4bit (optional RX_PARITY_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_fsm_4bit;

  localparam int CPB = 16;
  localparam logic [1:0] K_VALID = 2'd0;
  localparam logic [1:0] K_FERR  = 2'd1;
  localparam logic [1:0] K_PERR  = 2'd2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [3:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;
  logic       parity_err;

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] data;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [1:0] mon_k;
  int         vectors     = 0;
  int         miscompares = 0;
  logic [3:0] exp_data    = 4'h0;

  rx_fsm_4bit #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Output-side scoreboard: every pulse must match the oldest expectation
  always @(negedge clk) begin
    if (data_valid || frame_err || parity_err) begin
      mon_k = data_valid ? K_VALID : (frame_err ? K_FERR : K_PERR);
      vectors++;
      assert ($countones({data_valid, frame_err, parity_err}) === 1) else begin
        miscompares++;
        $error("FAIL pulse_exclusive observed=%b expected=one-hot", {data_valid, frame_err, parity_err});
      end
      if (sb.size() == 0) begin
        miscompares++;
        $error("FAIL unexpected_pulse observed=kind%0d data=%h expected=none", mon_k, data_out);
      end else begin
        mon_e = sb.pop_front();
        vectors++;
        assert (mon_k === mon_e.kind) else begin
          miscompares++;
          $error("FAIL pulse_kind observed=%0d expected=%0d", mon_k, mon_e.kind);
        end
        vectors++;
        assert (data_out === mon_e.data) else begin
          miscompares++;
          $error("FAIL pulse_data observed=%h expected=%h", data_out, mon_e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] obs, input logic [3:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", name, obs, expv);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_time(input logic v);
    rx = v;
    cycles(CPB);
  endtask

  task automatic send_frame(input logic [3:0] d, input logic stop, input logic par);
    exp_t e;
    if (!stop) begin
      e.kind = K_FERR;
`ifdef RX_PARITY_EN
    end else if (par != ^d) begin
      e.kind = K_PERR;
`endif
    end else begin
      e.kind   = K_VALID;
      exp_data = d;
    end
    e.data = exp_data;
    sb.push_back(e);
    bit_time(1'b0);
    rx = d[0];
    cycles(CPB / 2);
    chk("busy_mid_frame", {3'b000, busy}, 4'h1);
    cycles(CPB / 2);
    for (int i = 1; i < 4; i++) bit_time(d[i]);
`ifdef RX_PARITY_EN
    bit_time(par);
`endif
    bit_time(stop);
    rx = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 * CPB && sb.size() != 0; i++) @(posedge clk);
    #1;
    vectors++;
    assert (sb.size() === 0) else begin
      miscompares++;
      $error("FAIL drain_timeout observed=%0d pending expected=0", sb.size());
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_data_out"}, data_out, 4'h0);
    chk({tag, "_pulses"}, {1'b0, data_valid, frame_err, parity_err}, 4'h0);
    chk({tag, "_busy"}, {3'b000, busy}, 4'h0);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    rx  = 1'b1;
    cycles(3);
    chk_idle_outputs("reset");
    rst = 1'b0;
    cycles(2 * CPB);

    // Basic frame A..D = 1,0,1,1
    send_frame(4'b1101, 1'b1, ^4'b1101);
    drain();
    chk("frame_1101", data_out, 4'b1101);
    chk("busy_after_frame", {3'b000, busy}, 4'h0);

    // Bad stop bit keeps previous data
    send_frame(4'hF, 1'b0, ^4'hF);
    cycles(3 * CPB);
    drain();
    chk("ferr_hold", data_out, 4'b1101);

    // Short start glitch
    rx = 1'b0;
    cycles(4);
    rx = 1'b1;
    cycles(3 * CPB);
    chk("glitch_busy", {3'b000, busy}, 4'h0);
    chk("glitch_hold", data_out, 4'b1101);

    // Back-to-back frames with no idle gap
    send_frame(4'h3, 1'b1, ^4'h3);
    send_frame(4'hA, 1'b1, ^4'hA);
    drain();
    chk("b2b_last", data_out, 4'hA);

    // Reset during bit C of frame 6, then a clean frame 6
    bit_time(1'b0);
    bit_time(1'b0);
    bit_time(1'b1);
    rx = 1'b1;
    cycles(CPB / 2);
    rst      = 1'b1;
    exp_data = 4'h0;
    cycles(2);
    chk_idle_outputs("midreset");
    rst = 1'b0;
    rx  = 1'b1;
    cycles(3 * CPB);
    chk("post_reset_busy", {3'b000, busy}, 4'h0);
    chk("post_reset_data", data_out, 4'h0);
    send_frame(4'h6, 1'b1, ^4'h6);
    drain();
    chk("frame_6", data_out, 4'h6);

    // Extreme data patterns
    send_frame(4'h0, 1'b1, 1'b0);
    send_frame(4'hF, 1'b1, 1'b0);
    drain();
    chk("frame_F", data_out, 4'hF);
    send_frame(4'h9, 1'b1, 1'b0);
    drain();
    chk("frame_9", data_out, 4'h9);

`ifdef RX_PARITY_EN
    // Parity error keeps previous data, good parity loads it
    send_frame(4'h7, 1'b1, 1'b0);
    drain();
    chk("perr_hold", data_out, 4'h9);
    send_frame(4'h7, 1'b1, 1'b1);
    drain();
    chk("parity_ok", data_out, 4'h7);
`endif

    cycles(2 * CPB);
    chk("final_data", data_out, exp_data);
    chk("final_busy", {3'b000, busy}, 4'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
